// File: rtl/csr_pkg.sv
// Shared CSR addresses, op encoding, sequencer states
// and mstatus bit positions for the machine-mode CSR file.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  typedef enum logic [1:0] {
    CSR_WRITE = 2'd0,
    CSR_SET   = 2'd1,
    CSR_CLEAR = 2'd2,
    CSR_NONE  = 2'd3
  } csr_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_TRAP_SAVE,
    S_TRAP_JUMP,
    S_MRET_JUMP
  } state_e;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;

endpackage

// File: rtl/csr_counter64.sv
// 64-bit counter, low/high halves separately writable.
// A write to either half suppresses the carry for that cycle.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_inc,
  input  logic        i_wr_lo,
  input  logic        i_wr_hi,
  input  logic [31:0] i_wdata,
  output logic [63:0] o_count
);

  logic [31:0] r_lo;
  logic [31:0] r_hi;
  logic        w_carry;

  assign w_carry = i_inc & (r_lo == 32'hFFFF_FFFF)
                 & ~i_wr_lo & ~i_wr_hi;
  assign o_count = {r_hi, r_lo};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lo <= '0;
      r_hi <= '0;
    end else begin
      if (i_wr_lo)    r_lo <= i_wdata;
      else if (i_inc) r_lo <= r_lo + 32'd1;
      if (i_wr_hi)      r_hi <= i_wdata;
      else if (w_carry) r_hi <= r_hi + 32'd1;
    end
  end

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR file with cycle/instret counters and
// a small sequencer for trap entry and mret redirects.
module csr_unit
  import csr_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] HART_ID     = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] csr_adr,
  input  logic [1:0]  csr_op_ctr,
  input  logic        csr_imm_en,
  input  logic        csr_read_en,
  input  logic        csr_wr_en,
  input  logic [4:0]  rs1_adr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] pc,
  input  logic        instr_retire,
  input  logic        trap_req,
  input  logic [31:0] trap_cause,
  input  logic        mret,
  output logic [31:0] csr_rdata,
  output logic        illegal,
  output logic        stall,
  output logic        redirect,
  output logic [31:0] redirect_pc
);

  state_e      r_state;
  state_e      w_state_nxt;
  logic        r_mie;
  logic        r_mpie;
  logic [31:0] r_mtvec;
  logic [31:0] r_mscratch;
  logic [31:0] r_mepc;
  logic [31:0] r_mcause;
  logic [31:0] r_pc_cap;
  logic [31:0] r_cause_cap;
  logic [63:0] w_cycle;
  logic [63:0] w_instret;
  logic [31:0] w_operand;
  logic [31:0] w_old;
  logic [31:0] w_new;
  logic        w_hit;
  logic        w_wr;
  logic        w_unused;

  assign w_operand = csr_imm_en ? {27'b0, rs1_adr} : rs1_data;
  assign w_unused  = ^r_pc_cap[1:0];

  always_comb begin
    w_hit = 1'b1;
    w_old = '0;
    unique case (csr_adr)
      CSR_MSTATUS:   w_old = {19'b0, 2'b11, 3'b0, r_mpie,
                              3'b0, r_mie, 3'b0};
      CSR_MTVEC:     w_old = r_mtvec;
      CSR_MSCRATCH:  w_old = r_mscratch;
      CSR_MEPC:      w_old = r_mepc;
      CSR_MCAUSE:    w_old = r_mcause;
      CSR_MCYCLE,
      CSR_CYCLE:     w_old = w_cycle[31:0];
      CSR_MCYCLEH,
      CSR_CYCLEH:    w_old = w_cycle[63:32];
      CSR_MINSTRET,
      CSR_INSTRET:   w_old = w_instret[31:0];
      CSR_MINSTRETH,
      CSR_INSTRETH:  w_old = w_instret[63:32];
      CSR_MHARTID:   w_old = HART_ID;
      default:       w_hit = 1'b0;
    endcase
  end

  always_comb begin
    w_new = w_old;
    unique case (csr_op_e'(csr_op_ctr))
      CSR_WRITE: w_new = w_operand;
      CSR_SET:   w_new = w_old | w_operand;
      CSR_CLEAR: w_new = w_old & ~w_operand;
      CSR_NONE:  w_new = w_old;
    endcase
  end

  assign csr_rdata = w_old;
  assign illegal   = (csr_read_en | csr_wr_en)
                   & (~w_hit | (csr_wr_en & (csr_adr[11:10] == 2'b11)));
  assign w_wr      = (r_state == S_IDLE) & csr_wr_en & ~illegal
                   & (csr_op_ctr != CSR_NONE);

  csr_counter64 u_mcycle (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (1'b1),
    .i_wr_lo (w_wr & (csr_adr == CSR_MCYCLE)),
    .i_wr_hi (w_wr & (csr_adr == CSR_MCYCLEH)),
    .i_wdata (w_new),
    .o_count (w_cycle)
  );

  csr_counter64 u_minstret (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (instr_retire),
    .i_wr_lo (w_wr & (csr_adr == CSR_MINSTRET)),
    .i_wr_hi (w_wr & (csr_adr == CSR_MINSTRETH)),
    .i_wdata (w_new),
    .o_count (w_instret)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    stall       = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    unique case (r_state)
      S_IDLE: begin
        stall = 1'b0;
        if (trap_req)  w_state_nxt = S_TRAP_SAVE;
        else if (mret) w_state_nxt = S_MRET_JUMP;
      end
      S_TRAP_SAVE: w_state_nxt = S_TRAP_JUMP;
      S_TRAP_JUMP: begin
        redirect    = 1'b1;
        redirect_pc = r_mtvec;
        w_state_nxt = S_IDLE;
      end
      S_MRET_JUMP: begin
        redirect    = 1'b1;
        redirect_pc = r_mepc;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Trap pc/cause are latched on acceptance; mepc updates one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mie       <= 1'b0;
      r_mpie      <= 1'b0;
      r_mtvec     <= MTVEC_RESET & ~32'h3;
      r_mscratch  <= '0;
      r_mepc      <= '0;
      r_mcause    <= '0;
      r_pc_cap    <= '0;
      r_cause_cap <= '0;
    end else begin
      if ((r_state == S_IDLE) && trap_req) begin
        r_pc_cap    <= pc;
        r_cause_cap <= trap_cause;
      end
      if (w_wr && (csr_adr == CSR_MSTATUS)) begin
        r_mie  <= w_new[MSTATUS_MIE];
        r_mpie <= w_new[MSTATUS_MPIE];
      end
      if (w_wr && (csr_adr == CSR_MTVEC))
        r_mtvec <= {w_new[31:2], 2'b00};
      if (w_wr && (csr_adr == CSR_MSCRATCH))
        r_mscratch <= w_new;
      if (w_wr && (csr_adr == CSR_MEPC))
        r_mepc <= {w_new[31:2], 2'b00};
      if (w_wr && (csr_adr == CSR_MCAUSE))
        r_mcause <= w_new;
      if (r_state == S_TRAP_SAVE) begin
        r_mepc   <= {r_pc_cap[31:2], 2'b00};
        r_mcause <= r_cause_cap;
        r_mpie   <= r_mie;
        r_mie    <= 1'b0;
      end
      if (r_state == S_MRET_JUMP) begin
        r_mie  <= r_mpie;
        r_mpie <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_csr_unit.sv
// Bench for csr_unit: vector table, trap/mret sequences,
// then random CSR traffic against a reference model.
module tb_csr_unit;

  localparam logic [31:0] MTV = 32'h0000_0401;
  localparam logic [31:0] HID = 32'h0000_0005;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] csr_adr;
  logic [1:0]  csr_op_ctr;
  logic        csr_imm_en;
  logic        csr_read_en;
  logic        csr_wr_en;
  logic [4:0]  rs1_adr;
  logic [31:0] rs1_data;
  logic [31:0] pc;
  logic        instr_retire;
  logic        trap_req;
  logic [31:0] trap_cause;
  logic        mret;
  logic [31:0] csr_rdata;
  logic        illegal;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;

  int n_chk  = 0;
  int n_pass = 0;

  csr_unit #(.MTVEC_RESET(MTV), .HART_ID(HID)) dut (
    .clk(clk), .rst(rst),
    .csr_adr(csr_adr), .csr_op_ctr(csr_op_ctr),
    .csr_imm_en(csr_imm_en), .csr_read_en(csr_read_en),
    .csr_wr_en(csr_wr_en), .rs1_adr(rs1_adr),
    .rs1_data(rs1_data), .pc(pc),
    .instr_retire(instr_retire), .trap_req(trap_req),
    .trap_cause(trap_cause), .mret(mret),
    .csr_rdata(csr_rdata), .illegal(illegal),
    .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] adr;
    logic [1:0]  op;
    logic        imm;
    logic        rd;
    logic        wr;
    logic [4:0]  ra;
    logic [31:0] rs;
    logic        cd;
    logic [31:0] ed;
    logic        ei;
  } vec_t;

  vec_t tv[19];

  // reference model state
  logic [63:0] m_cycle, m_inst;
  logic [31:0] m_scr, m_tvec, m_epc, m_cause;
  logic        m_mie, m_mpie;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic quiet();
    csr_adr = 12'h000; csr_op_ctr = 2'd3; csr_imm_en = 1'b0;
    csr_read_en = 1'b0; csr_wr_en = 1'b0; rs1_adr = 5'd0;
    rs1_data = 32'd0; instr_retire = 1'b0;
    trap_req = 1'b0; mret = 1'b0;
  endtask

  task automatic drv(logic [11:0] a, logic [1:0] op, logic imm,
                     logic rd, logic wr, logic [4:0] ra,
                     logic [31:0] rs);
    csr_adr = a; csr_op_ctr = op; csr_imm_en = imm;
    csr_read_en = rd; csr_wr_en = wr; rs1_adr = ra; rs1_data = rs;
  endtask

  task automatic rd_chk(string nm, logic [11:0] a, logic [31:0] exp);
    drv(a, 2'd3, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
    #1;
    chk(nm, csr_rdata, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [32:0] ref_rd(logic [11:0] a);
    case (a)
      12'h300: return {1'b1, 32'h1800 | (32'(m_mpie) << 7)
                                      | (32'(m_mie) << 3)};
      12'h305: return {1'b1, m_tvec};
      12'h340: return {1'b1, m_scr};
      12'h341: return {1'b1, m_epc};
      12'h342: return {1'b1, m_cause};
      12'hB00, 12'hC00: return {1'b1, m_cycle[31:0]};
      12'hB80, 12'hC80: return {1'b1, m_cycle[63:32]};
      12'hB02, 12'hC02: return {1'b1, m_inst[31:0]};
      12'hB82, 12'hC82: return {1'b1, m_inst[63:32]};
      12'hF14: return {1'b1, HID};
      default: return {1'b0, 32'd0};
    endcase
  endfunction

  logic [11:0] adrs[16] = '{12'h300, 12'h305, 12'h340, 12'h341,
                            12'h342, 12'hB00, 12'hB02, 12'hB80,
                            12'hB82, 12'hC00, 12'hC02, 12'hC80,
                            12'hC82, 12'hF14, 12'h7C0, 12'h301};

  initial begin
    tv[0]  = '{12'h300, 2'd3, 1'b0, 1'b1, 1'b0, 5'd0,  32'h0,         1'b1, 32'h0000_1800, 1'b0};
    tv[1]  = '{12'h305, 2'd3, 1'b0, 1'b1, 1'b0, 5'd0,  32'h0,         1'b1, 32'h0000_0400, 1'b0};
    tv[2]  = '{12'hF14, 2'd3, 1'b0, 1'b1, 1'b0, 5'd0,  32'h0,         1'b1, 32'h0000_0005, 1'b0};
    tv[3]  = '{12'h340, 2'd0, 1'b0, 1'b1, 1'b1, 5'd0,  32'hF0F0_F0F0, 1'b1, 32'h0000_0000, 1'b0};
    tv[4]  = '{12'h340, 2'd1, 1'b1, 1'b1, 1'b1, 5'h0F, 32'hFFFF_FFFF, 1'b1, 32'hF0F0_F0F0, 1'b0};
    tv[5]  = '{12'h340, 2'd2, 1'b0, 1'b1, 1'b1, 5'h1F, 32'hF000_0000, 1'b1, 32'hF0F0_F0FF, 1'b0};
    tv[6]  = '{12'h340, 2'd3, 1'b0, 1'b1, 1'b0, 5'd0,  32'h0,         1'b1, 32'h00F0_F0FF, 1'b0};
    tv[7]  = '{12'hC00, 2'd0, 1'b0, 1'b1, 1'b1, 5'd0,  32'h0,         1'b0, 32'h0,         1'b1};
    tv[8]  = '{12'h7C0, 2'd3, 1'b0, 1'b1, 1'b0, 5'd0,  32'h0,         1'b0, 32'h0,         1'b1};
    tv[9]  = '{12'hF14, 2'd0, 1'b0, 1'b0, 1'b1, 5'd0,  32'h0,         1'b1, 32'h0000_0005, 1'b1};
    tv[10] = '{12'h341, 2'd3, 1'b0, 1'b1, 1'b0, 5'd0,  32'h0,         1'b1, 32'h0000_0000, 1'b0};
    tv[11] = '{12'h305, 2'd0, 1'b0, 1'b1, 1'b1, 5'd0,  32'h0000_0203, 1'b1, 32'h0000_0400, 1'b0};
    tv[12] = '{12'h305, 2'd3, 1'b0, 1'b1, 1'b0, 5'd0,  32'h0,         1'b1, 32'h0000_0200, 1'b0};
    tv[13] = '{12'h342, 2'd3, 1'b0, 1'b1, 1'b0, 5'd0,  32'h0,         1'b1, 32'h0000_0000, 1'b0};
    tv[14] = '{12'h300, 2'd0, 1'b0, 1'b1, 1'b1, 5'd0,  32'hFFFF_FFFF, 1'b1, 32'h0000_1800, 1'b0};
    tv[15] = '{12'h300, 2'd3, 1'b0, 1'b1, 1'b0, 5'd0,  32'h0,         1'b1, 32'h0000_1888, 1'b0};
    tv[16] = '{12'h300, 2'd2, 1'b0, 1'b1, 1'b1, 5'd0,  32'h0000_0088, 1'b1, 32'h0000_1888, 1'b0};
    tv[17] = '{12'h300, 2'd3, 1'b0, 1'b1, 1'b0, 5'd0,  32'h0,         1'b1, 32'h0000_1800, 1'b0};
    tv[18] = '{12'h7C0, 2'd0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,         1'b0, 32'h0,         1'b0};

    rst = 1'b1;
    quiet();
    pc = 32'd0;
    trap_cause = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst stall", {31'd0, stall}, 32'd0);
    chk("rst redirect", {31'd0, redirect}, 32'd0);
    chk("rst redirect_pc", redirect_pc, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 19; i++) begin
      drv(tv[i].adr, tv[i].op, tv[i].imm, tv[i].rd, tv[i].wr,
          tv[i].ra, tv[i].rs);
      #1;
      if (tv[i].cd) chk($sformatf("vec%0d rdata", i), csr_rdata, tv[i].ed);
      chk($sformatf("vec%0d illegal", i), {31'd0, illegal}, {31'd0, tv[i].ei});
      step();
    end

    // counter keeps running through an illegal write; low-half wrap
    drv(12'hB00, 2'd0, 1'b0, 1'b0, 1'b1, 5'd0, 32'h0000_1000);
    step();
    drv(12'hC00, 2'd0, 1'b0, 1'b1, 1'b1, 5'd0, 32'h0);
    #1;
    chk("cycle wr illegal", {31'd0, illegal}, 32'd1);
    chk("cycle wr old", csr_rdata, 32'h0000_1000);
    step();
    rd_chk("cycle counting", 12'hC00, 32'h0000_1001);
    step();
    drv(12'hB00, 2'd0, 1'b0, 1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF);
    step();
    rd_chk("mcycle max", 12'hB00, 32'hFFFF_FFFF);
    step();
    rd_chk("mcycle wrap lo", 12'hB00, 32'h0);
    step();
    rd_chk("mcycleh carry", 12'hB80, 32'h1);
    step();

    // trap entry
    drv(12'h300, 2'd1, 1'b1, 1'b1, 1'b1, 5'd8, 32'h0);
    #1;
    chk("set mie old", csr_rdata, 32'h1800);
    step();
    quiet();
    trap_req = 1'b1; pc = 32'h100; trap_cause = 32'hB;
    #1;
    chk("trap T stall", {31'd0, stall}, 32'd0);
    step();
    trap_req = 1'b0; pc = 32'h999;
    drv(12'h340, 2'd0, 1'b0, 1'b1, 1'b1, 5'd0, 32'hDEAD);
    #1;
    chk("trap T1 stall", {31'd0, stall}, 32'd1);
    chk("trap T1 redirect", {31'd0, redirect}, 32'd0);
    step();
    quiet();
    #1;
    chk("trap T2 stall", {31'd0, stall}, 32'd1);
    chk("trap T2 redirect", {31'd0, redirect}, 32'd1);
    chk("trap T2 pc", redirect_pc, 32'h200);
    step();
    #1;
    chk("trap T3 stall", {31'd0, stall}, 32'd0);
    chk("trap T3 redirect", {31'd0, redirect}, 32'd0);
    rd_chk("trap mepc", 12'h341, 32'h100);
    step();
    rd_chk("trap mcause", 12'h342, 32'hB);
    step();
    rd_chk("trap mstatus", 12'h300, 32'h1880);
    step();
    rd_chk("busy write dropped", 12'h340, 32'h00F0_F0FF);
    step();

    // mret
    quiet();
    mret = 1'b1;
    #1;
    chk("mret T stall", {31'd0, stall}, 32'd0);
    step();
    mret = 1'b0;
    #1;
    chk("mret T1 stall", {31'd0, stall}, 32'd1);
    chk("mret T1 redirect", {31'd0, redirect}, 32'd1);
    chk("mret T1 pc", redirect_pc, 32'h100);
    step();
    #1;
    chk("mret T2 stall", {31'd0, stall}, 32'd0);
    rd_chk("mret mstatus", 12'h300, 32'h1888);
    step();

    // trap and mret together: trap wins
    quiet();
    trap_req = 1'b1; mret = 1'b1; pc = 32'h44; trap_cause = 32'h3;
    step();
    quiet();
    #1;
    chk("both T1 stall", {31'd0, stall}, 32'd1);
    chk("both T1 redirect", {31'd0, redirect}, 32'd0);
    step();
    #1;
    chk("both T2 redirect", {31'd0, redirect}, 32'd1);
    chk("both T2 pc", redirect_pc, 32'h200);
    step();
    rd_chk("both mepc", 12'h341, 32'h44);
    step();
    rd_chk("both mcause", 12'h342, 32'h3);
    step();
    rd_chk("both mstatus", 12'h300, 32'h1880);
    step();

    // reset while in TRAP_SAVE
    quiet();
    trap_req = 1'b1; pc = 32'h300; trap_cause = 32'h7;
    step();
    quiet();
    rst = 1'b1;
    #1;
    chk("abort stall", {31'd0, stall}, 32'd0);
    chk("abort redirect", {31'd0, redirect}, 32'd0);
    rst = 1'b0;
    step();
    rd_chk("abort mepc", 12'h341, 32'h0);
    step();
    rd_chk("abort mcause", 12'h342, 32'h0);
    step();
    rd_chk("abort mstatus", 12'h300, 32'h1800);
    step();
    rd_chk("abort mtvec", 12'h305, 32'h400);
    #1;
    chk("abort idle stall", {31'd0, stall}, 32'd0);

    // random traffic against the model, from a fresh reset
    quiet();
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_cycle = '0; m_inst = '0; m_scr = '0; m_tvec = 32'h400;
    m_epc = '0; m_cause = '0; m_mie = 1'b0; m_mpie = 1'b0;
    for (int k = 0; k < 400; k++) begin
      logic [11:0] a;
      logic [1:0]  op;
      logic        imm, rd, wr, ret, hit, ill;
      logic [4:0]  ra;
      logic [31:0] rs, opnd, old, nv;
      logic [32:0] r;
      a   = adrs[$urandom_range(0, 15)];
      op  = 2'($urandom_range(0, 2));
      imm = 1'($urandom_range(0, 1));
      rd  = 1'($urandom_range(0, 1));
      wr  = 1'($urandom_range(0, 1));
      ra  = 5'($urandom);
      rs  = $urandom;
      ret = 1'($urandom_range(0, 1));
      if ((a == 12'hB80 || a == 12'hB82) && ($urandom_range(0, 3) != 0))
        rs = 32'hFFFF_FFFF;
      drv(a, op, imm, rd, wr, ra, rs);
      instr_retire = ret;
      #1;
      r   = ref_rd(a);
      hit = r[32];
      old = r[31:0];
      ill = (rd | wr) & (~hit | (wr & (a[11:10] == 2'b11)));
      if (hit) chk($sformatf("rnd%0d rdata", k), csr_rdata, old);
      chk($sformatf("rnd%0d illegal", k), {31'd0, illegal}, {31'd0, ill});
      opnd = imm ? {27'd0, ra} : rs;
      nv = (op == 2'd0) ? opnd :
           (op == 2'd1) ? (old | opnd) : (old & ~opnd);
      step();
      if (wr && !ill && a == 12'hB00)      m_cycle = {m_cycle[63:32], nv};
      else if (wr && !ill && a == 12'hB80) m_cycle = {nv, m_cycle[31:0] + 32'd1};
      else                                 m_cycle = m_cycle + 64'd1;
      if (wr && !ill && a == 12'hB02)      m_inst = {m_inst[63:32], nv};
      else if (wr && !ill && a == 12'hB82) m_inst = {nv, m_inst[31:0] + 32'(ret)};
      else                                 m_inst = m_inst + 64'(ret);
      if (wr && !ill) begin
        case (a)
          12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
          12'h305: m_tvec = nv & ~32'h3;
          12'h340: m_scr = nv;
          12'h341: m_epc = nv & ~32'h3;
          12'h342: m_cause = nv;
          default: ;
        endcase
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
